// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: shared types and constants for the memory access scheduler.
//   ROB_INVALID  - tag shown on cdb_rob when no broadcast is in progress
//   sched_state_e - scheduler FSM states
//   mem_op_e     - latched operation of the in-flight access
//   STARVE_W / LAT_W - widths of the starvation and latency counters
package mem_sched_pkg;

    localparam int unsigned STARVE_W = 4;
    localparam int unsigned LAT_W    = 4;

    localparam logic [5:0] ROB_INVALID = 6'd16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        BCAST
    } sched_state_e;

    typedef enum logic {
        OP_LD = 1'b0,
        OP_ST = 1'b1
    } mem_op_e;

endpackage

// File: rtl/mem_access_scheduler_lat.sv
// mem_lat_timer: memory latency down-counter.
//   clock, reset - system clock, asynchronous active-high reset
//   load_i       - reload with MEM_LAT-1 (request accepted this edge)
//   dec_i        - count down (an access is in progress)
//   done_o       - high while the count is zero, i.e. the last ACCESS cycle
module mem_lat_timer
    import mem_sched_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);

    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;

    always_comb begin
        lat_cnt_d = lat_cnt_q;
        if (load_i) begin
            lat_cnt_d = LAT_W'(MEM_LAT - 1);
        end else if (dec_i && (lat_cnt_q != '0)) begin
            lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_cnt_q <= '0;
        end else begin
            lat_cnt_q <= lat_cnt_d;
        end
    end

    assign done_o = (lat_cnt_q == '0);

endmodule

// File: rtl/mem_access_scheduler.sv
// mem_access_scheduler: shares the single data-memory port between load issue
// and store commit, runs each access for MEM_LAT cycles and broadcasts load
// results on a CDB lane with a req/grant handshake.
//   clock, reset              - clock, asynchronous active-high reset
//   ld_valid/ld_addr/ld_rob   - load request in;  ld_ready - load accepted
//   st_valid/st_addr/st_data  - store commit in;  st_ready - store accepted
//   flush                     - ROB flush, aborts an in-flight load
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - memory port
//   cdb_req/cdb_grant/cdb_data/cdb_rob         - CDB broadcast handshake
//   busy                      - scheduler not in IDLE
// Optional: define MEMSCHED_ST_FWD_EN to forward the last store's data to a
// load of the same address without a memory access.
module mem_access_scheduler
    import mem_sched_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ROB_W        = 6,
    parameter int unsigned MEM_LAT      = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [ROB_W-1:0]  ld_rob,
    output logic              ld_ready,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    input  logic              flush,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cdb_req,
    input  logic              cdb_grant,
    output logic [DATA_W-1:0] cdb_data,
    output logic [ROB_W-1:0]  cdb_rob,
    output logic              busy
);

    sched_state_e         state_q;
    mem_op_e              op_q;
    logic [ROB_W-1:0]     rob_q;
    logic [STARVE_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic                 mem_en_q, mem_we_q, cdb_req_q, busy_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_wdata_q, cdb_data_q;
    logic [ROB_W-1:0]     cdb_rob_q;

    logic                 idle, load_prio, ld_win, ld_grant, st_grant, lat_done;
    logic                 fwd_hit;
    logic [DATA_W-1:0]    fwd_data;

    // Readies are gated by reset so every output reads 0 while reset is held.
    assign idle      = (state_q == IDLE) && !reset;
    assign load_prio = (starve_cnt_q >= STARVE_W'(STARVE_LIMIT));
    // A flushed load never wins, so a waiting store may proceed instead.
    assign ld_win    = ld_valid && !flush && (load_prio || !st_valid);
    assign ld_grant  = idle && ld_win;
    assign st_grant  = idle && st_valid && !ld_win;
    assign ld_ready  = ld_grant;
    assign st_ready  = st_grant;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (ld_grant) begin
            starve_cnt_d = '0;
        end else if (st_grant && ld_valid && (starve_cnt_q != '1)) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
    end

    mem_lat_timer #(
        .MEM_LAT(MEM_LAT)
    ) u_lat_timer (
        .clock (clock),
        .reset (reset),
        .load_i(ld_grant || st_grant),
        .dec_i (state_q == ACCESS),
        .done_o(lat_done)
    );

`ifdef MEMSCHED_ST_FWD_EN
    logic              fwd_valid_q;
    logic [ADDR_W-1:0] fwd_addr_q;
    logic [DATA_W-1:0] fwd_data_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
        end else if (st_grant) begin
            fwd_valid_q <= 1'b1;
            fwd_addr_q  <= st_addr;
            fwd_data_q  <= st_data;
        end
    end

    assign fwd_hit  = fwd_valid_q && (fwd_addr_q == ld_addr);
    assign fwd_data = fwd_data_q;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= OP_LD;
            rob_q        <= '0;
            starve_cnt_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cdb_req_q    <= 1'b0;
            cdb_data_q   <= '0;
            cdb_rob_q    <= ROB_W'(ROB_INVALID);
            busy_q       <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            case (state_q)
                IDLE: begin
                    if (st_grant) begin
                        state_q     <= ACCESS;
                        op_q        <= OP_ST;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= st_addr;
                        mem_wdata_q <= st_data;
                        busy_q      <= 1'b1;
                    end else if (ld_grant) begin
                        op_q   <= OP_LD;
                        rob_q  <= ld_rob;
                        busy_q <= 1'b1;
                        if (fwd_hit) begin
                            state_q    <= BCAST;
                            cdb_req_q  <= 1'b1;
                            cdb_data_q <= fwd_data;
                            cdb_rob_q  <= ld_rob;
                        end else begin
                            state_q    <= ACCESS;
                            mem_en_q   <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= ld_addr;
                        end
                    end
                end
                ACCESS: begin
                    if ((op_q == OP_LD) && flush) begin
                        state_q  <= IDLE;
                        mem_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (lat_done) begin
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (op_q == OP_ST) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q    <= BCAST;
                            cdb_req_q  <= 1'b1;
                            cdb_data_q <= mem_rdata;
                            cdb_rob_q  <= rob_q;
                        end
                    end
                end
                BCAST: begin
                    // A grant on the flush edge still completes the broadcast;
                    // both paths end the same way.
                    if (cdb_grant || flush) begin
                        state_q   <= IDLE;
                        cdb_req_q <= 1'b0;
                        cdb_rob_q <= ROB_W'(ROB_INVALID);
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cdb_req   = cdb_req_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_rob   = cdb_rob_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_access_scheduler.sv
// tb_mem_access_scheduler: self-checking bench for mem_access_scheduler.
// Arbitration table plus directed sequences; every CDB broadcast is checked
// against a scoreboard filled when loads are accepted.
module tb_mem_access_scheduler;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ROB_W  = 6;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              ld_valid = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [ROB_W-1:0]  ld_rob = '0;
    logic              ld_ready;
    logic              st_valid = 1'b0;
    logic [ADDR_W-1:0] st_addr = '0;
    logic [DATA_W-1:0] st_data = '0;
    logic              st_ready;
    logic              flush = 1'b0;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              cdb_req;
    logic              cdb_grant = 1'b1;
    logic [DATA_W-1:0] cdb_data;
    logic [ROB_W-1:0]  cdb_rob;
    logic              busy;

    mem_access_scheduler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROB_W(ROB_W),
        .MEM_LAT(2), .STARVE_LIMIT(4)
    ) dut (
        .clock(clock), .reset(reset),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_rob(ld_rob), .ld_ready(ld_ready),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .flush(flush),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_data(cdb_data), .cdb_rob(cdb_rob),
        .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rdata_for(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'hA5A5, ~a[15:0]};
    endfunction

    assign mem_rdata = rdata_for(mem_addr);

    int errors = 0;
    int checks = 0;
    int bcasts = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard of expected broadcasts
    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  rob;
    } bc_t;
    bc_t sb_q[$];

`ifdef MEMSCHED_ST_FWD_EN
    logic        m_fwd_v = 1'b0;
    logic [31:0] m_fwd_a = '0;
    logic [31:0] m_fwd_d = '0;
`endif

    // Inputs change only at the falling edge (+0..+2); sample at +3 to see
    // exactly what the next rising edge will act on.
    always begin
        bc_t e;
        @(negedge clock);
        #3;
        if (reset) begin
            sb_q.delete();
`ifdef MEMSCHED_ST_FWD_EN
            m_fwd_v = 1'b0;
`endif
        end else begin
            if (cdb_req && cdb_grant) begin
                bcasts++;
                check("cdb_bcast_pending", 64'(sb_q.size()), 64'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("cdb_bcast", {cdb_data, cdb_rob}, {e.data, e.rob});
                end
            end else if (flush) begin
                sb_q.delete();
            end
            if (ld_valid && ld_ready) begin
                e.rob  = ld_rob;
                e.data = rdata_for(ld_addr);
`ifdef MEMSCHED_ST_FWD_EN
                if (m_fwd_v && m_fwd_a == ld_addr) e.data = m_fwd_d;
`endif
                sb_q.push_back(e);
            end
`ifdef MEMSCHED_ST_FWD_EN
            if (st_valid && st_ready) begin
                m_fwd_v = 1'b1;
                m_fwd_a = st_addr;
                m_fwd_d = st_data;
            end
`endif
        end
    end

    task automatic issue_load(input logic [31:0] a, input logic [5:0] r);
        @(negedge clock);
        ld_valid = 1'b1; ld_addr = a; ld_rob = r;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (ld_ready) break;
            @(negedge clock);
        end
        check("ld_accept", ld_ready, 1'b1);
        @(negedge clock);
        ld_valid = 1'b0;
    endtask

    task automatic issue_store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        st_valid = 1'b1; st_addr = a; st_data = d;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (st_ready) break;
            @(negedge clock);
        end
        check("st_accept", st_ready, 1'b1);
        @(negedge clock);
        st_valid = 1'b0;
    endtask

    task automatic wait_cdb_req();
        for (int i = 0; i < 40; i++) begin
            if (cdb_req) break;
            @(negedge clock);
        end
        check("cdb_req_seen", cdb_req, 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!busy && !cdb_req) break;
            @(negedge clock);
        end
        check("idle_reached", {busy, cdb_req}, 2'b00);
    endtask

    task automatic count_stores(input string tag);
        int stores = 0;
        int we_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (mem_en && mem_we) we_cycles++;
            if (ld_ready) break;
            if (st_ready) stores++;
            @(negedge clock);
            st_data = st_data + 32'd1;
        end
        check({tag, "_ld_granted"}, ld_ready, 1'b1);
        check({tag, "_stores"}, 64'(stores), 64'd4);
        check({tag, "_we_cycles"}, 64'(we_cycles), 64'd8);
    endtask

    typedef struct {
        logic ld, st, fl;
        logic ld_rdy, st_rdy;
    } arb_vec_t;
    arb_vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        vecs[0] = '{0, 0, 0, 0, 0};
        vecs[1] = '{1, 0, 0, 1, 0};
        vecs[2] = '{0, 1, 0, 0, 1};
        vecs[3] = '{1, 1, 0, 0, 1};
        vecs[4] = '{1, 0, 1, 0, 0};
        vecs[5] = '{1, 1, 1, 0, 1};
        vecs[6] = '{0, 1, 1, 0, 1};
        vecs[7] = '{0, 0, 1, 0, 0};

        // Reset state, with requests present to show readies are held low
        #1 reset = 1'b1; ld_valid = 1'b1; st_valid = 1'b1;
        #2;
        check("rst_ctrl", {mem_en, mem_we, cdb_req, busy, ld_ready, st_ready}, 6'b0);
        check("rst_data", {mem_addr, mem_wdata}, 64'd0);
        check("rst_cdb", {cdb_data, cdb_rob}, {32'd0, 6'd16});
        @(negedge clock);
        ld_valid = 1'b0; st_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        // Arbitration table in IDLE (starvation count is zero)
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            ld_valid = vecs[i].ld; st_valid = vecs[i].st; flush = vecs[i].fl;
            ld_addr = 32'h40 + 32'(i); st_addr = 32'h80 + 32'(i);
            #1;
            check($sformatf("arb_%0d", i), {ld_ready, st_ready, busy},
                  {vecs[i].ld_rdy, vecs[i].st_rdy, 1'b0});
            #1;
            ld_valid = 1'b0; st_valid = 1'b0; flush = 1'b0;
        end

        // Load only, immediate grant
        cdb_grant = 1'b1;
        issue_load(32'h100, 6'd5);
        check("ld_c1", {mem_en, mem_we, busy, cdb_req, mem_addr}, {4'b1010, 32'h100});
        @(negedge clock);
        check("ld_c2", {mem_en, cdb_req}, 2'b10);
        @(negedge clock);
        check("ld_c3", {cdb_req, mem_en, busy, cdb_data, cdb_rob}, {3'b101, 32'hDEAD_BEEF, 6'd5});
        @(negedge clock);
        check("ld_c4", {cdb_req, busy, cdb_rob}, {2'b00, 6'd16});

        // Contention: four store grants, then the load; twice to show the count cleared
        @(negedge clock);
        ld_valid = 1'b1; ld_addr = 32'h300; ld_rob = 6'd11;
        st_valid = 1'b1; st_addr = 32'h400; st_data = 32'h1000;
        count_stores("starve1");
        @(negedge clock);
        ld_addr = 32'h304; ld_rob = 6'd12;
        count_stores("starve2");
        @(negedge clock);
        ld_valid = 1'b0; st_valid = 1'b0;
        wait_idle();

        // CDB backpressure
        cdb_grant = 1'b0;
        issue_load(32'h180, 6'd21);
        wait_cdb_req();
        st_valid = 1'b1; st_addr = 32'h600; st_data = 32'h66;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold_%0d", i), {cdb_req, cdb_data, cdb_rob},
                  {1'b1, rdata_for(32'h180), 6'd21});
            #1;
            check($sformatf("bp_st_ready_%0d", i), st_ready, 1'b0);
            @(negedge clock);
        end
        cdb_grant = 1'b1;
        issue_store(32'h600, 32'h66);
        wait_idle();

        // Flush in the second ACCESS cycle of a load, store waiting
        issue_load(32'h140, 6'd9);
        st_valid = 1'b1; st_addr = 32'h500; st_data = 32'h77;
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("fl_idle", {busy, cdb_req}, 2'b00);
        #1;
        check("fl_st_ready", st_ready, 1'b1);
        @(negedge clock);
        st_valid = 1'b0;
        check("fl_st_access", {mem_en, mem_we, mem_addr}, {2'b11, 32'h500});
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("fl_store_unaffected", {mem_en, mem_we, mem_wdata}, {2'b11, 32'h77});
        wait_idle();

        // Flush in BCAST without grant: no broadcast
        cdb_grant = 1'b0;
        issue_load(32'h1A0, 6'd14);
        wait_cdb_req();
        b0 = bcasts;
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flb_abort", {cdb_req, busy, cdb_rob}, {2'b00, 6'd16});
        #4;
        check("flb_no_bcast", 64'(bcasts - b0), 64'd0);

        // Flush and grant on the same edge: broadcast completes
        issue_load(32'h1C0, 6'd30);
        wait_cdb_req();
        b0 = bcasts;
        flush = 1'b1; cdb_grant = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flg_done", {cdb_req, busy}, 2'b00);
        check("flg_bcast", 64'(bcasts - b0), 64'd1);

        // Asynchronous reset during BCAST
        cdb_grant = 1'b0;
        issue_load(32'h1E0, 6'd3);
        wait_cdb_req();
        #1 reset = 1'b1;
        #1;
        check("rst_async", {cdb_req, busy, mem_en, cdb_rob}, {3'b000, 6'd16});
        @(negedge clock);
        reset = 1'b0;
        cdb_grant = 1'b1;

`ifdef MEMSCHED_ST_FWD_EN
        issue_store(32'h200, 32'h55);
        wait_idle();
        issue_load(32'h200, 6'd7);
        check("fwd_bcast", {mem_en, cdb_req, cdb_data, cdb_rob}, {2'b01, 32'h55, 6'd7});
        wait_idle();
`endif

        // Assorted loads through the scoreboard
        for (int i = 0; i < 6; i++) begin
            issue_load({16'h0, 4'h8, 10'($urandom_range(0, 1023)), 2'b00},
                       6'($urandom_range(0, 15)));
            wait_idle();
        end

        @(negedge clock);
        @(negedge clock);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
